// File: rtl/fibo_requester.sv
// fibo_requester: command-side front end for the Fibonacci engine.
// Queues 12-bit operand requests, presents one at a time on eng_operand
// (held for the whole transaction), ignores eng_ready for SETTLE cycles after
// each operand change, then waits for eng_ready or a TIMEOUT and returns the
// captured result on a valid/ready response port.
//
// Optional feature: define FIBO_REQ_RECOVER_EN to pulse eng_reset for one cycle
// and force eng_operand to 0 when a transaction times out.
//
// Ports:
//   CLK, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake, req_operand = Fibonacci index
//   eng_operand         operand driven to the engine
//   eng_reset           one-cycle engine recovery reset (FIBO_REQ_RECOVER_EN)
//   eng_ready/result    engine done flag and result
//   rsp_valid/ready     response handshake
//   rsp_operand/result  operand and captured result (result 0 on timeout)
//   rsp_timeout         response is a timeout
//   busy                transaction in progress or requests queued
module fibo_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [11:0] req_operand,
  output logic        req_ready,
  output logic [11:0] eng_operand,
  output logic        eng_reset,
  input  logic        eng_ready,
  input  logic [15:0] eng_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [11:0] rsp_operand,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int unsigned OP_W  = 12;
  localparam int unsigned RES_W = 16;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Operand queue storage and bookkeeping
  logic [OP_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  // FSM state and counters
  state_t           state;
  state_t           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [SET_W-1:0] settle_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_nxt;

  // Next values of the registered outputs
  logic [OP_W-1:0]  eng_operand_nxt;
  logic             eng_reset_nxt;
  logic             rsp_valid_nxt;
  logic [OP_W-1:0]  rsp_operand_nxt;
  logic [RES_W-1:0] rsp_result_nxt;
  logic             rsp_timeout_nxt;

  // req_ready is a registered copy of "queue not full", so a push never
  // depends on a same-cycle pop.
  assign push      = req_valid && req_ready;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // State and output registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      req_ready   <= 1'b1;
      eng_operand <= '0;
      eng_reset   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_operand <= '0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_nxt;
      to_cnt      <= to_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      req_ready   <= (count_nxt < CNT_W'(DEPTH));
      eng_operand <= eng_operand_nxt;
      eng_reset   <= eng_reset_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_operand <= rsp_operand_nxt;
      rsp_result  <= rsp_result_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      busy        <= (state_nxt != IDLE) || (count_nxt != '0);
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= req_operand;
  end

  // Next-state and output logic
  always_comb begin
    state_nxt       = state;
    settle_nxt      = settle_cnt;
    to_nxt          = to_cnt;
    pop             = 1'b0;
    eng_operand_nxt = eng_operand;
    eng_reset_nxt   = 1'b0;
    rsp_valid_nxt   = rsp_valid;
    rsp_operand_nxt = rsp_operand;
    rsp_result_nxt  = rsp_result;
    rsp_timeout_nxt = rsp_timeout;

    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop             = 1'b1;
          eng_operand_nxt = mem[rd_ptr];
          rsp_operand_nxt = mem[rd_ptr];
          settle_nxt      = '0;
          state_nxt       = LOAD;
        end
      end
      // eng_ready may still reflect the previous operand here
      LOAD: begin
        if (settle_cnt == SET_W'(SETTLE - 1)) begin
          to_nxt    = '0;
          state_nxt = WAIT;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      WAIT: begin
        if (eng_ready) begin
          rsp_result_nxt  = eng_result;
          rsp_timeout_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          rsp_result_nxt  = '0;
          rsp_timeout_nxt = 1'b1;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
`ifdef FIBO_REQ_RECOVER_EN
          // Restart the engine from a clean operand
          eng_reset_nxt   = 1'b1;
          eng_operand_nxt = '0;
`endif
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fibo_requester.sv
// Testbench for fibo_requester: directed steps plus a randomized phase,
// checked against a queue-based scoreboard and an arithmetic Fibonacci model.
`timescale 1ns/1ps
module tb_fibo_requester;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [11:0] req_operand;
  logic        req_ready;
  logic [11:0] eng_operand;
  logic        eng_reset;
  logic        eng_ready;
  logic [15:0] eng_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_operand;
  logic [15:0] rsp_result;
  logic        rsp_timeout;
  logic        busy;

  always #5 CLK = ~CLK;

  fibo_requester #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_operand(req_operand), .req_ready(req_ready),
    .eng_operand(eng_operand), .eng_reset(eng_reset),
    .eng_ready(eng_ready), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_operand(rsp_operand),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  logic [11:0] exp_q[$];          // operands accepted, not yet answered

  // Engine model controls and state
  bit          hang = 1'b0;       // engine never signals ready
  bit          stale_en = 1'b0;   // keep old ready/result for SETTLE cycles
  int          lat_max = 0;
  logic [11:0] eng_cur = '0;
  int          eng_cnt = 0;
  int          stale_left = 0;

  // Fibonacci with F(0)=F(1)=1, wrapped to 16 bits
  function automatic logic [15:0] fib(input logic [11:0] n);
    logic [15:0] a, b, t;
    a = 16'd1;
    b = 16'd1;
    for (int i = 2; i <= int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic engine_step();
    if (eng_operand != eng_cur) begin
      eng_cur    = eng_operand;
      eng_cnt    = int'($urandom_range(lat_max, 0));
      stale_left = stale_en ? int'(SETTLE) : 0;
    end
    if (stale_left > 0) begin
      stale_left--;
    end else if (hang) begin
      eng_ready  = 1'b0;
      eng_result = 16'($urandom);
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      eng_ready  = 1'b0;
      eng_result = 16'($urandom);
    end else begin
      eng_ready  = 1'b1;
      eng_result = fib(eng_cur);
    end
  endtask

  task automatic check_rsp();
    logic [11:0] op;
    rsp_seen++;
    if (exp_q.size() == 0) begin
      chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      op = exp_q.pop_front();
      chk("rsp_operand", 32'(rsp_operand), 32'(op));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(hang));
      chk("rsp_result", 32'(rsp_result), hang ? 32'd0 : 32'(fib(op)));
      if (!hang) chk("eng_operand_held", 32'(eng_operand), 32'(op));
    end
  endtask

  // One clock: record handshakes due at this edge, advance, update engine
  task automatic tick();
    logic        rst_now;
    logic [11:0] op_before;
    if (!reset && req_valid && req_ready) exp_q.push_back(req_operand);
    if (!reset && rsp_valid && rsp_ready) check_rsp();
    rst_now   = reset;
    op_before = eng_operand;
    @(posedge CLK);
    #1;
    if (!rst_now && eng_operand !== op_before) begin
      if (eng_reset === 1'b1)     chk("recover_operand", 32'(eng_operand), 32'd0);
      else if (exp_q.size() == 0) chk("pop_without_request", 32'(eng_operand), 32'(op_before));
      else                        chk("eng_operand_pop", 32'(eng_operand), 32'(exp_q[0]));
    end
    engine_step();
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),   32'd1);
    chk({tag, "_eng_operand"}, 32'(eng_operand), 32'd0);
    chk({tag, "_eng_reset"},   32'(eng_reset),   32'd0);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_operand"}, 32'(rsp_operand), 32'd0);
    chk({tag, "_rsp_result"},  32'(rsp_result),  32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  initial begin
    int          n;
    int          idx;
    int          seen0;
    bit          accept;
    logic [11:0] ops [6];
    logic [11:0] op;

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_operand = '0;
    rsp_ready   = 1'b1;
    eng_ready   = 1'b0;
    eng_result  = '0;

    // Reset values
    tick();
    tick();
    chk_reset_vals("por");
    reset = 1'b0;
    tick();

    // Single request, minimum latency
    lat_max = 0;
    stale_en = 1'b0;
    req_valid = 1'b1;
    req_operand = 12'd5;
    tick();
    req_valid = 1'b0;
    chk("busy_after_push", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("push_to_rsp_latency", 32'(n), 32'(SETTLE + 2));
    chk("single_rsp_result", 32'(rsp_result), 32'd8);
    drain("single", 20);

    // Back-to-back 5, 10, 0, 3
    lat_max = 3;
    seen0 = rsp_seen;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: req_operand = 12'd5;
        1: req_operand = 12'd10;
        2: req_operand = 12'd0;
        default: req_operand = 12'd3;
      endcase
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    drain("b2b", 200);
    chk("b2b_count", 32'(rsp_seen - seen0), 32'd4);

    // Stale ready from operand 5 must not be taken as the result for 10
    lat_max = 0;
    req_valid = 1'b1;
    req_operand = 12'd5;
    tick();
    req_valid = 1'b0;
    drain("stale_pre", 40);
    stale_en = 1'b1;
    lat_max = 4;
    req_valid = 1'b1;
    req_operand = 12'd10;
    tick();
    req_valid = 1'b0;
    drain("stale", 60);
    stale_en = 1'b0;

    // Backpressure: consumer stalls for 50 cycles while 6 requests arrive
    lat_max = 2;
    rsp_ready = 1'b0;
    seen0 = rsp_seen;
    for (int i = 0; i < 6; i++) ops[i] = 12'($urandom_range(20, 0));
    idx = 0;
    for (int c = 0; c < 50; c++) begin
      req_valid   = (idx < 6);
      req_operand = (idx < 6) ? ops[idx] : 12'd0;
      accept      = req_valid && req_ready;
      tick();
      if (accept) idx++;
      if (c == 20) begin
        chk("bp_accepted", 32'(idx), 32'(DEPTH + 1));
        chk("bp_req_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_stalled", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_operand", 32'(rsp_operand), 32'(ops[0]));
      end
    end
    rsp_ready = 1'b1;
    n = 0;
    while (idx < 6 && n < 200) begin
      req_valid   = 1'b1;
      req_operand = ops[idx];
      accept      = req_ready;
      tick();
      if (accept) idx++;
      n++;
    end
    req_valid = 1'b0;
    chk("bp_sixth_accepted", 32'(idx), 32'd6);
    drain("bp", 300);
    chk("bp_count", 32'(rsp_seen - seen0), 32'd6);

    // Timeout: engine never becomes ready
    hang = 1'b1;
    lat_max = 0;
    op = 12'($urandom_range(20, 1));
    req_valid = 1'b1;
    req_operand = op;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(1 + SETTLE + TIMEOUT));
    chk("timeout_flag", 32'(rsp_timeout), 32'd1);
`ifdef FIBO_REQ_RECOVER_EN
    chk("recover_eng_reset", 32'(eng_reset), 32'd1);
    chk("recover_eng_operand", 32'(eng_operand), 32'd0);
`else
    chk("norecover_eng_reset", 32'(eng_reset), 32'd0);
    chk("norecover_eng_operand", 32'(eng_operand), 32'(op));
`endif
    tick();
    chk("eng_reset_one_cycle", 32'(eng_reset), 32'd0);
    hang = 1'b0;
    drain("timeout", 20);

    // Reset while waiting with two requests queued
    hang = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_operand = 12'(i + 4);
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_vals("midreset");
    reset = 1'b0;
    exp_q.delete();
    hang = 1'b0;
    seen0 = rsp_seen;
    for (int i = 0; i < 30; i++) tick();
    chk("no_rsp_after_reset", 32'(rsp_seen - seen0), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Randomized traffic against the scoreboard
    seen0 = rsp_seen;
    idx = 0;
    for (int c = 0; c < 400; c++) begin
      stale_en = ($urandom_range(3, 0) == 0);
      lat_max  = int'($urandom_range(5, 0));
      rsp_ready = ($urandom_range(9, 0) < 7);
      req_valid = ($urandom_range(1, 0) == 1);
      req_operand = 12'($urandom_range(20, 0));
      if (req_valid && req_ready) idx++;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("rand", 500);
    chk("rand_count", 32'(rsp_seen - seen0), 32'(idx));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
